// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the load/store path.
// One transaction in flight; data has priority, bounded by a streak counter.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | arbitrate; grants only here
  // WAIT  | mem_req held, counting wait states
  // RESP  | one-cycle rvalid to the winner
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int CW = $clog2(TIMEOUT);

  state_t            state, state_nxt;
  logic [SW-1:0]     streak;
  logic [CW-1:0]     wait_cnt;
  logic              owner_d;
  logic              data_win, fetch_win, timeout;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  always_comb begin
    state_nxt = state;
    data_win  = 1'b0;
    fetch_win = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        data_win  = d_req && !(if_req && (streak == SW'(MAX_D_STREAK)));
        fetch_win = if_req && !data_win;
        if (data_win || fetch_win) state_nxt = WAIT;
      end
      WAIT: begin
        timeout = (wait_cnt == CW'(TIMEOUT - 1));
        if (mem_ack || timeout) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign if_gnt = fetch_win;
  assign d_gnt  = data_win;

  // Ack wins over a simultaneous timeout; stores never return memory data.
  assign resp_data = (mem_ack && !mem_wen) ? mem_rdata : '0;
  assign resp_err  = !mem_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak    <= '0;
      wait_cnt  <= '0;
      owner_d   <= 1'b0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_win) begin
            owner_d   <= 1'b1;
            mem_req   <= 1'b1;
            mem_wen   <= d_wen;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wait_cnt  <= '0;
            if (!if_req)                            streak <= '0;
            else if (streak != SW'(MAX_D_STREAK))   streak <= streak + 1'b1;
          end else if (fetch_win) begin
            owner_d   <= 1'b0;
            mem_req   <= 1'b1;
            mem_wen   <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            streak    <= '0;
          end
        end
        WAIT: begin
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
            if (owner_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= resp_data;
              d_err    <= resp_err;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= resp_data;
              if_err    <= resp_err;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if_rvalid <= 1'b0;
          d_rvalid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, starvation bound,
// timeout, ack on last cycle and reset mid-wait.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_wen;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_wen, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_d;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_wen", mem_wen, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    rst = 1'b0;

    // fetch only, zero-wait ack
    tick();
    if_req = 1'b1; if_addr = 32'h100; #1;
    chk1("f_if_gnt", if_gnt, 1'b1);
    chk1("f_d_gnt", d_gnt, 1'b0);
    tick();
    if_req = 1'b0; if_addr = 32'hFFFF; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
    chk1("f_mem_req", mem_req, 1'b1);
    chk32("f_mem_addr", mem_addr, 32'h100);
    chk1("f_mem_wen", mem_wen, 1'b0);
    chk1("f_no_gnt_wait", if_gnt, 1'b0);
    tick();
    mem_ack = 1'b0; #1;
    chk1("f_if_rvalid", if_rvalid, 1'b1);
    chk32("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk1("f_if_err", if_err, 1'b0);
    chk1("f_d_rvalid", d_rvalid, 1'b0);
    chk1("f_mem_req_drop", mem_req, 1'b0);
    tick();
    chk1("f_rvalid_pulse", if_rvalid, 1'b0);
    chk32("f_rdata_hold", if_rdata, 32'hDEADBEEF);

    // store with ack in the 4th wait cycle
    d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; #1;
    chk1("s_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; d_wen = 1'b0; d_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3); mem_rdata = 32'hCAFEF00D; #1;
      chk1("s_mem_req", mem_req, 1'b1);
      chk1("s_mem_wen", mem_wen, 1'b1);
      chk32("s_mem_wdata", mem_wdata, 32'h12345678);
      chk32("s_mem_addr", mem_addr, 32'h40);
      tick();
    end
    mem_ack = 1'b0; #1;
    chk1("s_d_rvalid", d_rvalid, 1'b1);
    chk32("s_d_rdata", d_rdata, 32'h0);
    chk1("s_d_err", d_err, 1'b0);
    chk1("s_if_rvalid", if_rvalid, 1'b0);
    tick();

    // starvation bound: D,D,D,D,IF repeated
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300;
    for (int k = 0; k < 10; k++) begin
      exp_d = ((k % 5) != 4);
      #1;
      chk1("sv_d_gnt", d_gnt, exp_d);
      chk1("sv_if_gnt", if_gnt, !exp_d);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(k); #1;
      chk32("sv_mem_addr", mem_addr, exp_d ? 32'h300 : 32'h200);
      tick();
      mem_ack = 1'b0; #1;
      if (exp_d) begin
        chk1("sv_d_rvalid", d_rvalid, 1'b1);
        chk32("sv_d_rdata", d_rdata, 32'h1000 + 32'(k));
      end else begin
        chk1("sv_if_rvalid", if_rvalid, 1'b1);
        chk32("sv_if_rdata", if_rdata, 32'h1000 + 32'(k));
      end
      tick();
    end
    if_req = 1'b0; d_req = 1'b0;

    // timeout on a load
    tick();
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h80; #1;
    chk1("t_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk1("t_mem_req", mem_req, 1'b1);
      tick();
    end
    chk1("t_mem_req_drop", mem_req, 1'b0);
    chk1("t_d_rvalid", d_rvalid, 1'b1);
    chk1("t_d_err", d_err, 1'b1);
    chk32("t_d_rdata", d_rdata, 32'h0);
    tick();
    d_req = 1'b1; d_addr = 32'h84; #1;
    chk1("t_next_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55; #1;
    tick();
    mem_ack = 1'b0; #1;
    chk1("t_next_err", d_err, 1'b0);
    chk32("t_next_rdata", d_rdata, 32'h55);
    tick();

    // ack on the final timeout cycle wins
    d_req = 1'b1; d_addr = 32'h88; #1;
    chk1("l_d_gnt", d_gnt, 1'b1);
    tick();
    d_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ack = (i == 15); mem_rdata = 32'hA5A5A5A5; #1;
      chk1("l_mem_req", mem_req, 1'b1);
      tick();
    end
    mem_ack = 1'b0; #1;
    chk1("l_d_rvalid", d_rvalid, 1'b1);
    chk1("l_d_err", d_err, 1'b0);
    chk32("l_d_rdata", d_rdata, 32'hA5A5A5A5);
    tick();

    // build streak, reset during 4th data wait, then streak must be 0
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("r_pre_d_gnt", d_gnt, 1'b1);
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h7; #1;
      tick();
      mem_ack = 1'b0; #1;
      tick();
    end
    #1;
    chk1("r_4th_d_gnt", d_gnt, 1'b1);
    tick();
    tick();
    if_req = 1'b0; d_req = 1'b0; #1;
    chk1("r_wait_mem_req", mem_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_ack = 1'b1; #1;
    chk1("r_mem_req_drop", mem_req, 1'b0);
    chk1("r_no_d_rvalid", d_rvalid, 1'b0);
    tick();
    mem_ack = 1'b0; #1;
    chk1("r_stray_ack_rvalid", d_rvalid, 1'b0);
    chk1("r_stray_ack_req", mem_req, 1'b0);
    if_req = 1'b1; d_req = 1'b1; #1;
    chk1("r_streak_clr_d_gnt", d_gnt, 1'b1);
    chk1("r_streak_clr_if_gnt", if_gnt, 1'b0);
    tick();
    if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99; #1;
    tick();
    mem_ack = 1'b0; #1;
    chk1("r_after_d_rvalid", d_rvalid, 1'b1);
    chk32("r_after_d_rdata", d_rdata, 32'h99);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
